pingpong_buffer_ctrl: RTL

- Sequencer for a two-bank (ping-pong) frame buffer in the IN -> BUFF -> OUT data path.
- The writer fills one bank while the reader drains the other. Bank roles swap on frame boundaries.
- Drives address and enable lines of an external dual-bank synchronous RAM with 1-cycle read latency.
- Performs the valid/ready handshake on both stream sides.

---
 rtl/pingpong_pkg.sv | 16 +
 rtl/pingpong_bank_fsm.sv | 35 +++
 rtl/pingpong_buffer_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong frame buffer sequencer.
package pingpong_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        FILLING  = 2'b01,
        FULL     = 2'b10,
        DRAINING = 2'b11
    } bank_state_t;

    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

    localparam int DEPTH_DEFAULT = 16;

endpackage

// File: rtl/pingpong_bank_fsm.sv
// Per-bank occupancy FSM: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
module pingpong_bank_fsm
    import pingpong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       fill_word,
    input  logic       fill_last,
    input  logic       drain_start,
    input  logic       drain_done,
    output logic [1:0] state
);

    bank_state_t state_q;
    bank_state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:    if (fill_word)              state_d = FILLING;
            FILLING:  if (fill_word && fill_last) state_d = FULL;
            FULL:     if (drain_start)            state_d = DRAINING;
            DRAINING: if (drain_done)             state_d = EMPTY;
            default:                              state_d = EMPTY;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/pingpong_buffer_ctrl.sv
// Two-bank ping-pong frame buffer sequencer with stream handshakes on both sides.
// Optional PINGPONG_STATS_EN adds frame and stall counters.
module pingpong_buffer_ctrl
    import pingpong_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [3:0]        bank_state
`ifdef PINGPONG_STATS_EN
    ,
    output logic [15:0]       frames_in,
    output logic [15:0]       frames_out,
    output logic [15:0]       stall_cycles
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [1:0] state0;
    logic [1:0] state1;
    logic [1:0] wr_state;
    logic [1:0] rd_state;
    logic       wr_last;
    logic       rd_issued_all;
    logic       last_q;
    logic       rd_done;

    assign wr_state = (wr_bank == BANK1) ? state1 : state0;
    assign rd_state = (rd_bank == BANK1) ? state1 : state0;

    assign in_ready = !reset && (wr_state == EMPTY || wr_state == FILLING);
    assign wr_en    = in_valid && in_ready;
    assign wr_last  = (wr_addr == LAST_ADDR);

    // rd_issued_all stops issuing once the whole frame has been read, while the
    // bank stays selected until its last word is taken downstream.
    assign rd_en    = !reset && (rd_state == FULL || rd_state == DRAINING)
                      && !rd_issued_all && (!out_valid || out_ready);
    assign out_last = out_valid && last_q;
    assign rd_done  = out_valid && out_ready && out_last;

    pingpong_bank_fsm u_bank0 (
        .clk         (clk),
        .reset       (reset),
        .fill_word   (wr_en && wr_bank == BANK0),
        .fill_last   (wr_last),
        .drain_start (rd_en && rd_bank == BANK0),
        .drain_done  (rd_done && rd_bank == BANK0),
        .state       (state0)
    );

    pingpong_bank_fsm u_bank1 (
        .clk         (clk),
        .reset       (reset),
        .fill_word   (wr_en && wr_bank == BANK1),
        .fill_last   (wr_last),
        .drain_start (rd_en && rd_bank == BANK1),
        .drain_done  (rd_done && rd_bank == BANK1),
        .state       (state1)
    );

    assign bank_state = {state1, state0};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank       <= BANK0;
            wr_addr       <= '0;
            rd_bank       <= BANK0;
            rd_addr       <= '0;
            rd_issued_all <= 1'b0;
            out_valid     <= 1'b0;
            last_q        <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_last) begin
                    wr_addr <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
            if (rd_en) begin
                last_q  <= (rd_addr == LAST_ADDR);
                rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
                if (rd_addr == LAST_ADDR) rd_issued_all <= 1'b1;
            end
            out_valid <= rd_en || (out_valid && !out_ready);
            if (rd_done) begin
                rd_bank       <= ~rd_bank;
                rd_issued_all <= 1'b0;
            end
        end
    end

`ifdef PINGPONG_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frames_in    <= '0;
            frames_out   <= '0;
            stall_cycles <= '0;
        end else begin
            if (wr_en && wr_last) frames_in <= frames_in + 1'b1;
            if (rd_done)          frames_out <= frames_out + 1'b1;
            if (in_valid && !in_ready && stall_cycles != '1)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule
